// File: rtl/loader_defs.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// default frame start byte and frame-field widths.
package loader_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  // Frame start byte
  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Length field is 16 bits; the word counter carries one extra bit so a
  // full-capacity image does not wrap before the final compare.
  localparam int LEN_W = 16;
  localparam int CNT_W = LEN_W + 1;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (MAGIC, LEN_LO, LEN_HI, payload,
// optional CSUM), assembles little-endian 32-bit words and writes them into
// port A of the instruction memory. The core is held in reset until a full,
// valid image is in place.
// Build option: define IMEM_LOADER_CHECKSUM_EN to expect and check a trailing
// XOR checksum byte after the payload.
module imem_loader
  import loader_defs::*;
#(
  parameter int         ADDR_W = 14,
  parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_en,
  output logic [3:0]        imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              error
);

  // Memory capacity in words, held at counter width for the length check
  localparam logic [CNT_W-1:0] CAPACITY = {{(CNT_W-1){1'b0}}, 1'b1} << ADDR_W;

  state_t           state_reg;
  logic [LEN_W-1:0] len_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       byte_idx_reg;
  logic [23:0]      word_reg;     // lanes 0..2; lane 3 comes straight from rx_data
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_reg;
`endif

  logic             accept;
  logic             is_magic;
  logic [LEN_W-1:0] full_len;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_word;

  assign accept    = rx_valid && rx_ready;
  assign is_magic  = (rx_data == MAGIC);
  assign full_len  = {rx_data, len_reg[7:0]};
  assign cnt_inc   = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_word = (cnt_inc == {1'b0, len_reg});

  // Frame-parsing FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      rx_ready     <= 1'b1;
      imem_en      <= 1'b0;
      imem_we      <= 4'h0;
      imem_addr    <= '0;
      imem_din     <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      error        <= 1'b0;
      len_reg      <= '0;
      cnt_reg      <= '0;
      byte_idx_reg <= '0;
      word_reg     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg     <= '0;
`endif
    end else begin
      // The write strobe is a single-cycle pulse; the link is stalled only
      // while that write is in flight.
      imem_en  <= 1'b0;
      imem_we  <= 4'h0;
      rx_ready <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (accept && is_magic) begin
            state_reg    <= ST_LEN0;
            cnt_reg      <= '0;
            byte_idx_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= '0;
`endif
          end
        end

        ST_LEN0: begin
          if (accept) begin
            len_reg[7:0] <= rx_data;
            state_reg    <= ST_LEN1;
          end
        end

        ST_LEN1: begin
          if (accept) begin
            len_reg <= full_len;
            if ({1'b0, full_len} > CAPACITY) begin
              state_reg <= ST_ERR;
              error     <= 1'b1;
              cpu_reset <= 1'b1;
            end else if (full_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_reg <= ST_CSUM;
`else
              state_reg <= ST_DONE;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
`endif
            end else begin
              state_reg <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (accept) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= csum_reg ^ rx_data;
`endif
            case (byte_idx_reg)
              2'd0: word_reg[7:0]   <= rx_data;
              2'd1: word_reg[15:8]  <= rx_data;
              2'd2: word_reg[23:16] <= rx_data;
              default: begin
                // Fourth byte completes the word: issue the write next cycle
                state_reg <= ST_WRITE;
                imem_en   <= 1'b1;
                imem_we   <= 4'hF;
                imem_addr <= cnt_reg[ADDR_W-1:0];
                imem_din  <= {rx_data, word_reg};
                rx_ready  <= 1'b0;
              end
            endcase
          end
        end

        ST_WRITE: begin
          cnt_reg <= cnt_inc;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_reg <= ST_CSUM;
`else
            state_reg <= ST_DONE;
            cpu_reset <= 1'b0;
            load_done <= 1'b1;
`endif
          end else begin
            state_reg <= ST_DATA;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept) begin
            if (rx_data == csum_reg) begin
              state_reg <= ST_DONE;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state_reg <= ST_ERR;
              error     <= 1'b1;
              cpu_reset <= 1'b1;
            end
          end
        end
`endif

        ST_DONE: begin
          if (accept && is_magic) begin
            state_reg    <= ST_LEN0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            cnt_reg      <= '0;
            byte_idx_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= '0;
`endif
          end
        end

        ST_ERR: begin
          if (accept && is_magic) begin
            state_reg    <= ST_LEN0;
            error        <= 1'b0;
            cnt_reg      <= '0;
            byte_idx_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= '0;
`endif
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: drives framed byte streams (fixed and random),
// predicts the memory writes and the final load status from the frame
// contents, and compares against what the loader drives onto the imem port.
module tb_imem_loader;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_en;
  logic [3:0]        imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_din;
  logic              cpu_reset;
  logic              load_done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_en(imem_en), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_din(imem_din), .cpu_reset(cpu_reset),
    .load_done(load_done), .error(error)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Observed imem traffic
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int rdy_low = 0;
  int en_low  = 0;
  int bad_we  = 0;

  // Expected traffic and outcome from the reference model
  logic [7:0]        frame[$];
  logic [ADDR_W-1:0] exp_a[$];
  logic [31:0]       exp_d[$];
  bit                exp_err;

  // Sample the imem port mid-cycle, well away from both clock edges
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      if (imem_en) begin
        wa_q.push_back(imem_addr);
        wd_q.push_back(imem_din);
        if (imem_we !== 4'hF) bad_we++;
        if (!rx_ready) en_low++;
      end else if (imem_we !== 4'h0) begin
        bad_we++;
      end
      if (!rx_ready) rdy_low++;
    end
  end

  task automatic clr_mon();
    wa_q.delete(); wd_q.delete();
    rdy_low = 0; en_low = 0; bad_we = 0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Offer one byte (after optional idle gap) and wait for the handshake
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok, acc;
    if (gap > 0) idle(gap);
    rx_valid = 1'b1;
    rx_data  = b;
    acc = 0;
    for (int t = 0; t < 8 && !acc; t++) begin
      ok = rx_ready;
      @(posedge clk);
      if (ok) acc = 1;
      @(negedge clk);
    end
    if (!acc) begin
      nchk++; nerr++;
      $display("FAIL handshake_timeout byte=%02h rx_ready never high", b);
    end
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame[i]) send_byte(frame[i], (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
    idle(3);
  endtask

  // Reference model: random payload, words are little-endian packs of each
  // 4-byte group, written to consecutive addresses from 0.
  task automatic build_frame(input int len, input bit corrupt);
    logic [7:0]  csum, v;
    logic [31:0] w;
    frame.delete(); exp_a.delete(); exp_d.delete();
    frame.push_back(8'hA5);
    frame.push_back(len[7:0]);
    frame.push_back(len[15:8]);
    exp_err = (len > (1 << ADDR_W));
    csum = 8'h00;
    if (!exp_err) begin
      for (int wi = 0; wi < len; wi++) begin
        w = 32'h0;
        for (int bi = 0; bi < 4; bi++) begin
          v = 8'($urandom);
          frame.push_back(v);
          csum = csum ^ v;
          w = w | (32'(v) << (8 * bi));
        end
        exp_a.push_back(ADDR_W'(wi));
        exp_d.push_back(w);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      frame.push_back(corrupt ? (csum ^ 8'h5A) : csum);
      if (corrupt) exp_err = 1;
`endif
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clr_mon();
  endtask

  task automatic test_reset();
    do_reset();
    nchk++; if ({rx_ready, imem_en, imem_we} !== 6'b1_0_0000) begin nerr++;
      $display("FAIL reset_port got rdy/en/we=%b want 100000", {rx_ready, imem_en, imem_we}); end
    nchk++; if ({imem_addr, imem_din} !== '0) begin nerr++;
      $display("FAIL reset_addr_din got %h/%h want 0/0", imem_addr, imem_din); end
    nchk++; if ({cpu_reset, load_done, error} !== 3'b100) begin nerr++;
      $display("FAIL reset_status got %b want 100", {cpu_reset, load_done, error}); end
  endtask

  task automatic test_basic();
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    send_frame(0);
    nchk++; if (wa_q.size() !== 2) begin nerr++;
      $display("FAIL basic_nwrites got %0d want 2", wa_q.size()); end
    else begin
      nchk++; if ({wa_q[0], wd_q[0]} !== {14'd0, 32'h00000013}) begin nerr++;
        $display("FAIL basic_w0 got %h:%h want 0:00000013", wa_q[0], wd_q[0]); end
      nchk++; if ({wa_q[1], wd_q[1]} !== {14'd1, 32'h00100093}) begin nerr++;
        $display("FAIL basic_w1 got %h:%h want 1:00100093", wa_q[1], wd_q[1]); end
    end
    nchk++; if ({rdy_low, en_low, bad_we} !== {32'd2, 32'd2, 32'd0}) begin nerr++;
      $display("FAIL basic_backpressure got low=%0d en_low=%0d bad_we=%0d want 2/2/0", rdy_low, en_low, bad_we); end
    nchk++; if ({cpu_reset, load_done, error} !== 3'b010) begin nerr++;
      $display("FAIL basic_done got %b want 010", {cpu_reset, load_done, error}); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_error();
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90, 8'h91};
    send_frame(0);
    nchk++; if (wa_q.size() !== 2) begin nerr++;
      $display("FAIL csum_nwrites got %0d want 2", wa_q.size()); end
    nchk++; if ({cpu_reset, load_done, error} !== 3'b101) begin nerr++;
      $display("FAIL csum_err got %b want 101", {cpu_reset, load_done, error}); end
    send_byte(8'hA5, 0);
    nchk++; if ({cpu_reset, error} !== 2'b10) begin nerr++;
      $display("FAIL csum_clear got rst/err=%b want 10", {cpu_reset, error}); end
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    nchk++; if ({cpu_reset, load_done, error} !== 3'b010) begin nerr++;
      $display("FAIL csum_recover got %b want 010", {cpu_reset, load_done, error}); end
  endtask
`endif

  task automatic test_zero_len();
    do_reset();
    build_frame(0, 0);
    send_frame(0);
    nchk++; if (wa_q.size() !== 0) begin nerr++;
      $display("FAIL zero_writes got %0d want 0", wa_q.size()); end
    nchk++; if ({cpu_reset, load_done, error} !== 3'b010) begin nerr++;
      $display("FAIL zero_done got %b want 010", {cpu_reset, load_done, error}); end
  endtask

  task automatic test_len_limit();
    logic [7:0] b[4];
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h40, 0);
    nchk++; if ({cpu_reset, load_done, error} !== 3'b101) begin nerr++;
      $display("FAIL limit_over got %b want 101", {cpu_reset, load_done, error}); end
    idle(2);
    nchk++; if (wa_q.size() !== 0) begin nerr++;
      $display("FAIL limit_over_writes got %0d want 0", wa_q.size()); end
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h40, 0);
    foreach (b[i]) begin b[i] = 8'($urandom); send_byte(b[i], 0); end
    idle(3);
    nchk++; if (error !== 1'b0) begin nerr++;
      $display("FAIL limit_exact_err got %b want 0", error); end
    nchk++; if (wa_q.size() !== 1) begin nerr++;
      $display("FAIL limit_exact_nwrites got %0d want 1", wa_q.size()); end
    else begin
      nchk++; if ({wa_q[0], wd_q[0]} !== {14'd0, b[3], b[2], b[1], b[0]}) begin nerr++;
        $display("FAIL limit_exact_w0 got %h:%h want 0:%h%h%h%h", wa_q[0], wd_q[0], b[3], b[2], b[1], b[0]); end
    end
    nchk++; if ({cpu_reset, load_done} !== 2'b10) begin nerr++;
      $display("FAIL limit_exact_busy got %b want 10", {cpu_reset, load_done}); end
  endtask

  task automatic test_junk_restart();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom);
      if (v == 8'hA5) v = 8'h5A;
      send_byte(v, 0);
    end
    build_frame(3, 0);
    send_frame(2);
    nchk++; if (wa_q.size() !== exp_a.size()) begin nerr++;
      $display("FAIL junk_nwrites got %0d want %0d", wa_q.size(), exp_a.size()); end
    else foreach (exp_a[i]) begin
      nchk++; if ({wa_q[i], wd_q[i]} !== {exp_a[i], exp_d[i]}) begin nerr++;
        $display("FAIL junk_w%0d got %h:%h want %h:%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]); end
    end
    nchk++; if ({cpu_reset, load_done, error} !== 3'b010) begin nerr++;
      $display("FAIL junk_done got %b want 010", {cpu_reset, load_done, error}); end
    send_byte(8'h3C, 0);
    nchk++; if ({cpu_reset, load_done} !== 2'b01) begin nerr++;
      $display("FAIL done_ignore got %b want 01", {cpu_reset, load_done}); end
    send_byte(8'hA5, 0);
    nchk++; if ({cpu_reset, load_done} !== 2'b10) begin nerr++;
      $display("FAIL restart got %b want 10", {cpu_reset, load_done}); end
    frame.delete();
    frame.push_back(8'h00); frame.push_back(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    send_frame(0);
    nchk++; if ({cpu_reset, load_done, error} !== 3'b010) begin nerr++;
      $display("FAIL restart_done got %b want 010", {cpu_reset, load_done, error}); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    build_frame(2, 0);
    for (int i = 0; i < 9; i++) send_byte(frame[i], 0);
    #2 reset = 1'b1;
    #1;
    nchk++; if ({cpu_reset, load_done, error, rx_ready, imem_en} !== 5'b10010) begin nerr++;
      $display("FAIL midreset_async got %b want 10010", {cpu_reset, load_done, error, rx_ready, imem_en}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clr_mon();
    build_frame(2, 0);
    send_frame(1);
    nchk++; if (wa_q.size() !== 2) begin nerr++;
      $display("FAIL midreset_nwrites got %0d want 2", wa_q.size()); end
    else foreach (exp_a[i]) begin
      nchk++; if ({wa_q[i], wd_q[i]} !== {exp_a[i], exp_d[i]}) begin nerr++;
        $display("FAIL midreset_w%0d got %h:%h want %h:%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]); end
    end
  endtask

  task automatic test_random();
    int len;
    bit bad;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      len = $urandom_range(6, 1);
      bad = ($urandom_range(1, 0) == 1);
      build_frame(len, bad);
      send_frame(3);
      nchk++; if (wa_q.size() !== exp_a.size()) begin nerr++;
        $display("FAIL rand%0d_nwrites got %0d want %0d", it, wa_q.size(), exp_a.size()); end
      else foreach (exp_a[i]) begin
        nchk++; if ({wa_q[i], wd_q[i]} !== {exp_a[i], exp_d[i]}) begin nerr++;
          $display("FAIL rand%0d_w%0d got %h:%h want %h:%h", it, i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]); end
      end
      nchk++; if ({rdy_low, bad_we} !== {len, 32'd0}) begin nerr++;
        $display("FAIL rand%0d_backpressure got low=%0d bad_we=%0d want %0d/0", it, rdy_low, bad_we, len); end
      nchk++; if ({cpu_reset, load_done, error} !== (exp_err ? 3'b101 : 3'b010)) begin nerr++;
        $display("FAIL rand%0d_status got %b want %b", it, {cpu_reset, load_done, error}, exp_err ? 3'b101 : 3'b010); end
      $display("rand%0d len=%0d corrupt=%0d writes=%0d status=%b", it, len, bad, wa_q.size(), {cpu_reset, load_done, error});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_error();
`endif
    test_zero_len();
    test_len_limit();
    test_junk_restart();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
